// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder: 68000 bus target serving a 16-bit register window with DTACK,
// plus a BERR watchdog for cycles that no slave claims.
module m68k_bus_responder #(
  parameter logic [23:0] BASE_ADDR   = 24'hE80000,
  parameter int          ADDR_W      = 4,
  parameter int          WAIT_STATES = 0,
  parameter int          TIMEOUT     = 64
) (
  input  logic        M68K_CLK,
  input  logic        M68K_RESET_n,
  input  logic [23:1] M68K_A,
  input  logic [2:0]  M68K_FC,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  input  logic [15:0] M68K_D_IN,
  output logic [15:0] M68K_D_OUT,
  output logic        M68K_D_OE,
  input  logic        M68K_DTACK_IN_n,
  output logic        M68K_DTACK_n,
  output logic        M68K_BERR_n,
  output logic [15:0] HIT_COUNT
);
  typedef enum logic [2:0] {IDLE, WAIT, ACK, MISS, HOLD} state_t;
  state_t state;
  logic as_q, rw_q, dtin_q;
  logic [1:0] ds_q;
  logic [23:1] a_q;
  logic [2:0] fc_q;
  logic [15:0] din_q;
  logic [3:0] wcnt;
  logic [7:0] tcnt;
  logic [15:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] word;
  logic hit, go;
  assign word = a_q[ADDR_W:1];
  assign hit = !as_q && fc_q != 3'b111 && a_q[23:ADDR_W+1] == BASE_ADDR[23:ADDR_W+1];
  // a write waits for its data strobes; a read is acknowledged regardless of strobes
  assign go = state == WAIT && !as_q && wcnt == 4'd0 && (rw_q || ds_q != 2'b11);
  always_ff @(posedge M68K_CLK or negedge M68K_RESET_n)
    if (!M68K_RESET_n) begin
      as_q   <= 1'b1;
      ds_q   <= 2'b11;
      rw_q   <= 1'b1;
      dtin_q <= 1'b1;
      a_q    <= '0;
      fc_q   <= '0;
      din_q  <= '0;
    end else begin
      as_q   <= M68K_AS_n;
      ds_q   <= {M68K_UDS_n, M68K_LDS_n};
      rw_q   <= M68K_RW;
      dtin_q <= M68K_DTACK_IN_n;
      a_q    <= M68K_A;
      fc_q   <= M68K_FC;
      din_q  <= M68K_D_IN;
    end
  always_ff @(posedge M68K_CLK) begin
    if (go && !rw_q && !ds_q[1]) mem[word][15:8] <= din_q[15:8];
    if (go && !rw_q && !ds_q[0]) mem[word][7:0] <= din_q[7:0];
  end
  always_ff @(posedge M68K_CLK or negedge M68K_RESET_n)
    if (!M68K_RESET_n) begin
      state        <= IDLE;
      wcnt         <= '0;
      tcnt         <= '0;
      M68K_DTACK_n <= 1'b1;
      M68K_BERR_n  <= 1'b1;
      M68K_D_OE    <= 1'b0;
      M68K_D_OUT   <= '0;
      HIT_COUNT    <= '0;
    end else
      case (state)
        IDLE: if (!as_q) begin
          state <= hit ? WAIT : MISS;
          wcnt  <= 4'(WAIT_STATES);
          tcnt  <= '0;
        end
        WAIT: if (as_q) state <= IDLE;
          else if (go) begin
            state        <= ACK;
            M68K_DTACK_n <= 1'b0;
            M68K_D_OE    <= rw_q;
            if (rw_q) M68K_D_OUT <= mem[word];
          end else if (wcnt != 4'd0) wcnt <= wcnt - 4'd1;
        ACK: if (as_q) begin
          state        <= IDLE;
          M68K_DTACK_n <= 1'b1;
          M68K_D_OE    <= 1'b0;
          HIT_COUNT    <= HIT_COUNT + 16'd1;
        end
        MISS: if (as_q) state <= IDLE;
          else if (!dtin_q) state <= HOLD;
          else if (tcnt == 8'(TIMEOUT - 1)) begin
            state       <= HOLD;
            M68K_BERR_n <= 1'b0;
          end else tcnt <= tcnt + 8'd1;
        HOLD: if (as_q) begin
          state       <= IDLE;
          M68K_BERR_n <= 1'b1;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_m68k_bus_responder.sv
// tb_m68k_bus_responder: two responders (0 and 3 wait states) on a shared bus, checked every
// cycle against a counting model of the bus protocol plus hand-computed expectations.
module tb_m68k_bus_responder;
  localparam logic [23:0] BASE = 24'hE80000;
  logic clk = 0, rst_n = 0;
  logic [23:1] a = '0;
  logic [2:0] fc = 3'b101;
  logic as_n = 1, uds = 1, lds = 1, rw = 1, dtin = 1, chk_on = 0;
  logic [15:0] din = '0;
  logic [1:0] dt, berr, oe;
  logic [15:0] dout [2];
  logic [15:0] hits [2];
  int n_pass = 0, n_total = 0;
  always #5 clk = ~clk;

  m68k_bus_responder #(.WAIT_STATES(0)) u0 (
    .M68K_CLK(clk), .M68K_RESET_n(rst_n), .M68K_A(a), .M68K_FC(fc), .M68K_AS_n(as_n),
    .M68K_UDS_n(uds), .M68K_LDS_n(lds), .M68K_RW(rw), .M68K_D_IN(din), .M68K_D_OUT(dout[0]),
    .M68K_D_OE(oe[0]), .M68K_DTACK_IN_n(dtin), .M68K_DTACK_n(dt[0]), .M68K_BERR_n(berr[0]),
    .HIT_COUNT(hits[0]));
  m68k_bus_responder #(.WAIT_STATES(3)) u3 (
    .M68K_CLK(clk), .M68K_RESET_n(rst_n), .M68K_A(a), .M68K_FC(fc), .M68K_AS_n(as_n),
    .M68K_UDS_n(uds), .M68K_LDS_n(lds), .M68K_RW(rw), .M68K_D_IN(din), .M68K_D_OUT(dout[1]),
    .M68K_D_OE(oe[1]), .M68K_DTACK_IN_n(dtin), .M68K_DTACK_n(dt[1]), .M68K_BERR_n(berr[1]),
    .HIT_COUNT(hits[1]));

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h at t=%0t", name, got, want, $time);
  endtask

  // model: per responder, count clocks the registered AS has been low and apply the timing rules
  int wst [2] = '{0, 3};
  logic [15:0] mm [2][16];
  logic exp_dt [2], exp_berr [2], exp_oe [2], acked [2], miss [2], held [2];
  logic [15:0] exp_dout [2], exp_hits [2];
  int nlow [2];
  logic m_as, m_rw, m_dtin;
  logic [1:0] m_ds;
  logic [23:1] m_a;
  logic [2:0] m_fc;
  logic [15:0] m_din;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        exp_dt[i] = 1; exp_berr[i] = 1; exp_oe[i] = 0; exp_dout[i] = 0; exp_hits[i] = 0;
        nlow[i] = 0; acked[i] = 0; miss[i] = 0; held[i] = 0;
      end
      m_as = 1; m_ds = 2'b11; m_rw = 1; m_dtin = 1; m_a = '0; m_fc = '0; m_din = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_as) begin
          if (acked[i]) exp_hits[i] = exp_hits[i] + 16'd1;
          exp_dt[i] = 1; exp_oe[i] = 0; exp_berr[i] = 1;
          nlow[i] = 0; acked[i] = 0; held[i] = 0;
        end else begin
          nlow[i]++;
          if (nlow[i] == 1) miss[i] = m_fc == 3'b111 || m_a[23:5] != BASE[23:5];
          else if (!miss[i]) begin
            if (!acked[i] && nlow[i] >= wst[i] + 2 && (m_rw || m_ds != 2'b11)) begin
              acked[i] = 1; exp_dt[i] = 0; exp_oe[i] = m_rw;
              if (m_rw) exp_dout[i] = mm[i][m_a[4:1]];
              else begin
                if (!m_ds[1]) mm[i][m_a[4:1]][15:8] = m_din[15:8];
                if (!m_ds[0]) mm[i][m_a[4:1]][7:0] = m_din[7:0];
              end
            end
          end else if (!held[i]) begin
            if (!m_dtin) held[i] = 1;
            else if (nlow[i] == 65) begin held[i] = 1; exp_berr[i] = 0; end
          end
        end
      end
      m_as = as_n; m_ds = {uds, lds}; m_rw = rw; m_dtin = dtin; m_a = a; m_fc = fc; m_din = din;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on && rst_n)
      for (int i = 0; i < 2; i++) begin
        check($sformatf("dtack%0d", i), 16'(dt[i]), 16'(exp_dt[i]));
        check($sformatf("berr%0d", i), 16'(berr[i]), 16'(exp_berr[i]));
        check($sformatf("oe%0d", i), 16'(oe[i]), 16'(exp_oe[i]));
        check($sformatf("dout%0d", i), dout[i], exp_dout[i]);
        check($sformatf("hits%0d", i), hits[i], exp_hits[i]);
      end
  end

  task automatic cyc(input logic [23:0] ad, input logic [2:0] f, input logic r,
                     input logic [1:0] s, input logic [15:0] d, input int dly, input int hold);
    @(negedge clk);
    a = ad[23:1]; fc = f; rw = r; din = d; as_n = 0;
    if (dly == 0) {uds, lds} = s;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (i == dly) {uds, lds} = s;
    end
    as_n = 1; uds = 1; lds = 1; rw = 1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat0, lat3;
    logic seen;
    repeat (3) @(posedge clk);
    #2;
    check("rst_dtack", 16'(dt), 16'h3);
    check("rst_berr", 16'(berr), 16'h3);
    check("rst_oe", 16'(oe), 16'h0);
    check("rst_dout", dout[0], 16'h0);
    check("rst_hits", hits[0], 16'h0);
    rst_n = 1;
    chk_on = 1;
    cyc(24'hE80004, 3'b101, 0, 2'b00, 16'hBEEF, 0, 8);
    cyc(24'hE80004, 3'b101, 1, 2'b00, 16'h0000, 0, 8);
    check("word_rd", dout[0], 16'hBEEF);
    check("word_rd_w3", dout[1], 16'hBEEF);
    check("hits_after_rw", hits[0], 16'd2);
    cyc(24'hE80004, 3'b101, 0, 2'b01, 16'h12AB, 0, 8);
    cyc(24'hE80004, 3'b101, 1, 2'b00, 16'h0000, 0, 8);
    check("uds_rd", dout[0], 16'h12EF);
    cyc(24'hE80004, 3'b101, 0, 2'b10, 16'h5634, 0, 8);
    cyc(24'hE80004, 3'b101, 1, 2'b00, 16'h0000, 0, 8);
    check("lds_rd", dout[0], 16'h1234);
    check("hits6_w3", hits[1], 16'd6);
    // latency measured from the clock edge on which the registered AS is first acted upon
    @(negedge clk);
    a = 23'h740002; fc = 3'b101; rw = 1; as_n = 0; uds = 0; lds = 0;
    @(posedge clk);
    @(posedge clk);
    lat0 = -1; lat3 = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (!dt[0] && lat0 < 0) lat0 = i;
      if (!dt[1] && lat3 < 0) lat3 = i;
    end
    check("lat_w0", 16'(lat0), 16'd1);
    check("lat_w3", 16'(lat3), 16'd4);
    check("oe_w3", 16'(oe[1]), 16'd1);
    check("dout_w3", dout[1], 16'h1234);
    @(negedge clk);
    as_n = 1; uds = 1; lds = 1;
    @(posedge clk); #1;
    check("rel_hold", 16'(dt), 16'h0);
    @(posedge clk); #1;
    check("rel_done", 16'(dt), 16'h3);
    repeat (2) @(negedge clk);
    @(negedge clk);
    a = 23'h000080; fc = 3'b101; rw = 1; as_n = 0; uds = 0; lds = 0;
    @(posedge clk);
    @(posedge clk);
    lat0 = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (!berr[0] && lat0 < 0) lat0 = i;
    end
    check("berr_lat", 16'(lat0), 16'd64);
    @(negedge clk);
    as_n = 1; uds = 1; lds = 1;
    @(posedge clk); #1;
    check("berr_hold", 16'(berr), 16'h0);
    @(posedge clk); #1;
    check("berr_rel", 16'(berr), 16'h3);
    repeat (2) @(negedge clk);
    @(negedge clk);
    a = 23'h000080; as_n = 0; uds = 0; lds = 0; seen = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 10) dtin = 0;
      if (berr != 2'b11) seen = 1;
    end
    as_n = 1; uds = 1; lds = 1; dtin = 1;
    repeat (3) @(negedge clk);
    check("claimed_no_berr", 16'(seen), 16'd0);
    cyc(24'hE80000, 3'b111, 1, 2'b00, 16'h0000, 0, 8);
    cyc(24'hE80020, 3'b101, 1, 2'b00, 16'h0000, 0, 8);
    check("miss_no_hit", hits[0], 16'd7);
    cyc(24'hE8001E, 3'b001, 0, 2'b00, 16'hA55A, 2, 8);
    cyc(24'hE8001E, 3'b001, 1, 2'b11, 16'h0000, 0, 8);
    check("nods_rd", dout[0], 16'hA55A);
    cyc(24'hE80002, 3'b101, 0, 2'b00, 16'h1111, 0, 8);
    cyc(24'hE80002, 3'b101, 0, 2'b00, 16'h7777, 0, 2);
    cyc(24'hE80002, 3'b101, 1, 2'b00, 16'h0000, 0, 8);
    check("short_wr_w0", dout[0], 16'h7777);
    check("short_wr_w3", dout[1], 16'h1111);
    check("hits_w0", hits[0], 16'd12);
    check("hits_w3", hits[1], 16'd11);
    @(negedge clk);
    a = 23'h740002; fc = 3'b101; rw = 1; as_n = 0; uds = 0; lds = 0;
    repeat (3) @(posedge clk);
    #2;
    check("mid_ack", 16'(dt[0]), 16'd0);
    rst_n = 0;
    #1;
    check("async_dtack", 16'(dt), 16'h3);
    check("async_berr", 16'(berr), 16'h3);
    check("async_oe", 16'(oe), 16'h0);
    check("async_hits", hits[0], 16'h0);
    @(negedge clk);
    as_n = 1; uds = 1; lds = 1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
    repeat (3) @(negedge clk);
    cyc(24'hE80004, 3'b101, 1, 2'b00, 16'h0000, 0, 8);
    check("mem_kept", dout[0], 16'h1234);
    check("hits_after_rst", hits[0], 16'd1);
    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
